// File: rtl/ifu_pkg.sv
// Shared constants and FSM state type for the I-fetch line fill unit.
// Holds word/line geometry defaults and the fill_state_t enum.
package ifu_pkg;

  localparam int WORD_WIDTH       = 32;
  localparam int DEF_TAG_WIDTH    = 28;
  localparam int DEF_LINE_WIDTH   = 128;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int WORDS_PER_LINE   = DEF_LINE_WIDTH / WORD_WIDTH;
  localparam int TIMEOUT_CYCLES   = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESPOND
  } fill_state_t;

endpackage

// File: rtl/ifu_mem_fill.sv
// I-cache miss fill: reads a line one word at a time and returns it.
// Ports: Clock/Rst (async high), cache_req*/cache_rsp* (cache side),
// mem_rd* (word read port), busyOut, errOut (timeout pulse).
// Optional fetch timeout: define IFU_MEM_FILL_TIMEOUT_EN.
module ifu_mem_fill #(
  parameter int TAG_WIDTH      = ifu_pkg::DEF_TAG_WIDTH,
  parameter int LINE_WIDTH     = ifu_pkg::DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH     = ifu_pkg::DEF_ADDR_WIDTH,
  parameter int OFFSET_WIDTH   = ifu_pkg::DEF_OFFSET_WIDTH,
  parameter int TIMEOUT_CYCLES = ifu_pkg::TIMEOUT_CYCLES
) (
  input  logic                          Clock,
  input  logic                          Rst,
  input  logic [TAG_WIDTH-1:0]          cache_reqTagIn,
  input  logic                          cache_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]          cache_rspTagOut,
  output logic [LINE_WIDTH-1:0]         cache_rspInsLineOut,
  output logic                          cache_rspInsLineValidOut,
  output logic                          mem_rdReqOut,
  output logic [ADDR_WIDTH-1:0]         mem_rdAddrOut,
  input  logic [ifu_pkg::WORD_WIDTH-1:0] mem_rdDataIn,
  input  logic                          mem_rdAckIn,
  output logic                          busyOut,
  output logic                          errOut
);
  import ifu_pkg::*;

  localparam int NW = LINE_WIDTH / WORD_WIDTH;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int OW = IW + 2;

  fill_state_t state, state_nx;

  logic [TAG_WIDTH-1:0]  tag_q;
  logic [IW-1:0]         idx_q;
  logic [WORD_WIDTH-1:0] buf_q [NW];
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [LINE_WIDTH-1:0] rsp_line_q;
  logic [LINE_WIDTH-1:0] line_nx;
  logic [OW-1:0]         word_off;
  logic                  fetch_ack;
  logic                  last_ack;
  logic                  timeout;

  assign fetch_ack = (state == FETCH) && mem_rdAckIn;
  assign last_ack  = fetch_ack && (idx_q == IW'(NW - 1));
  assign word_off  = {idx_q, 2'b00};

  // The final word bypasses the buffer so the response register
  // can be loaded on the same edge that accepts it.
  always_comb begin
    line_nx = '0;
    for (int i = 0; i < NW; i++) begin
      if (i == NW - 1)
        line_nx[i*WORD_WIDTH +: WORD_WIDTH] = mem_rdDataIn;
      else
        line_nx[i*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
    end
  end

`ifdef IFU_MEM_FILL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign timeout = (state == FETCH) && !mem_rdAckIn &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign errOut  = err_q;

  // Cleared outside FETCH, so it is already zero on FETCH entry.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state != FETCH || mem_rdAckIn)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign errOut  = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cache_reqTagValidIn) state_nx = FETCH;
      FETCH: begin
        if (last_ack)     state_nx = RESPOND;
        else if (timeout) state_nx = IDLE;
      end
      RESPOND: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      rsp_tag_q  <= '0;
      rsp_line_q <= '0;
      for (int i = 0; i < NW; i++) buf_q[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cache_reqTagValidIn) begin
        tag_q <= cache_reqTagIn;
        idx_q <= '0;
      end
      if (fetch_ack) begin
        buf_q[idx_q] <= mem_rdDataIn;
        idx_q <= (idx_q == IW'(NW - 1)) ? '0 : idx_q + IW'(1);
      end
      if (last_ack) begin
        rsp_tag_q  <= tag_q;
        rsp_line_q <= line_nx;
      end
    end
  end

  assign mem_rdReqOut  = (state == FETCH);
  assign mem_rdAddrOut = (state == FETCH) ?
    ADDR_WIDTH'({tag_q, OFFSET_WIDTH'(word_off)}) : '0;

  assign cache_rspTagOut          = rsp_tag_q;
  assign cache_rspInsLineOut      = rsp_line_q;
  assign cache_rspInsLineValidOut = (state == RESPOND);
  assign busyOut                  = (state != IDLE);

endmodule

// File: tb/tb_ifu_mem_fill.sv
// Scoreboard bench for ifu_mem_fill with a randomized memory model.
// Timeout scenario follows IFU_MEM_FILL_TIMEOUT_EN.
module tb_ifu_mem_fill;

  localparam int TW = 28;
  localparam int LW = 128;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int NW = LW / WW;
  localparam int TO = 8;

  typedef struct {
    logic [TW-1:0] tag;
    logic [LW-1:0] line;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Rst;
  logic [TW-1:0] cache_reqTagIn;
  logic          cache_reqTagValidIn;
  logic [TW-1:0] cache_rspTagOut;
  logic [LW-1:0] cache_rspInsLineOut;
  logic          cache_rspInsLineValidOut;
  logic          mem_rdReqOut;
  logic [AW-1:0] mem_rdAddrOut;
  logic [WW-1:0] mem_rdDataIn;
  logic          mem_rdAckIn;
  logic          busyOut;
  logic          errOut;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   resp_cnt = 0;

  int            mem_delay = 0;
  bit            mem_en = 1'b1;
  bit            spurious = 1'b0;
  bit            fixed = 1'b0;
  int            mem_idx = 0;
  int            ack_cnt = 0;
  int            wait_cnt = 0;
  bit            held = 1'b0;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] exp_addr;

  ifu_mem_fill #(
    .TAG_WIDTH(TW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW),
    .OFFSET_WIDTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(Clock),
    .Rst(Rst),
    .cache_reqTagIn(cache_reqTagIn),
    .cache_reqTagValidIn(cache_reqTagValidIn),
    .cache_rspTagOut(cache_rspTagOut),
    .cache_rspInsLineOut(cache_rspInsLineOut),
    .cache_rspInsLineValidOut(cache_rspInsLineValidOut),
    .mem_rdReqOut(mem_rdReqOut),
    .mem_rdAddrOut(mem_rdAddrOut),
    .mem_rdDataIn(mem_rdDataIn),
    .mem_rdAckIn(mem_rdAckIn),
    .busyOut(busyOut),
    .errOut(errOut)
  );

  always #5 Clock = ~Clock;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Line of tag t: word i lives at byte address t*16 + 4*i.
  function automatic exp_t model(input logic [TW-1:0] t);
    exp_t e;
    e.tag = t;
    e.line = '0;
    for (int i = 0; i < NW; i++)
      e.line[i*WW +: WW] = mem_word((AW'(t) << 4) + AW'(4 * i));
    return e;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Memory: random or fixed wait per word, data derived from address.
  always @(negedge Clock) begin
    if (spurious) begin
      mem_rdAckIn = 1'b1;
      mem_rdDataIn = 32'hDEAD_BEEF;
    end else if (mem_en && mem_rdReqOut === 1'b1) begin
      if (held) begin
        checks++;
        if (mem_rdAddrOut !== last_addr) begin
          errors++;
          $display("FAIL addr_stable actual=%h required=%h",
                   mem_rdAddrOut, last_addr);
        end
      end else begin
        wait_cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
      if (wait_cnt == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL addr_no_fill actual=%h required=none", mem_rdAddrOut);
        end else begin
          exp_addr = (AW'(exp_q[0].tag) << 4) + AW'(4 * mem_idx);
          if (mem_rdAddrOut !== exp_addr) begin
            errors++;
            $display("FAIL rd_addr actual=%h required=%h",
                     mem_rdAddrOut, exp_addr);
          end
        end
        mem_rdAckIn = 1'b1;
        mem_rdDataIn = fixed ? 32'(32'h11 * (mem_idx + 1))
                             : mem_word(mem_rdAddrOut);
        mem_idx = (mem_idx + 1) % NW;
        ack_cnt++;
        held = 1'b0;
      end else begin
        mem_rdAckIn = 1'b0;
        wait_cnt--;
        held = 1'b1;
        last_addr = mem_rdAddrOut;
      end
    end else begin
      mem_rdAckIn = 1'b0;
      held = 1'b0;
    end
  end

  // Monitor: every line-valid pulse pops one expected response.
  always @(negedge Clock) begin
    if (Rst === 1'b0 && cache_rspInsLineValidOut === 1'b1) begin
      resp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=%h required=none",
                 cache_rspTagOut);
      end else begin
        mon_e = exp_q.pop_front();
        last_exp = mon_e;
        if (cache_rspTagOut !== mon_e.tag ||
            cache_rspInsLineOut !== mon_e.line) begin
          errors++;
          $display("FAIL rsp_line actual=%h/%h required=%h/%h",
                   cache_rspTagOut, cache_rspInsLineOut,
                   mon_e.tag, mon_e.line);
        end
      end
    end
  end

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (cache_rspInsLineValidOut !== 1'b1 && n < 300) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_wait actual=no_pulse required=pulse", nm);
    end
  endtask

  task automatic fill(input logic [TW-1:0] t);
    exp_q.push_back(model(t));
    cache_reqTagIn = t;
    cache_reqTagValidIn = 1'b1;
    @(negedge Clock);
    wait_rsp("fill");
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int r0;
    int a0;
    exp_t e;

    Rst = 1'b1;
    cache_reqTagIn = '0;
    cache_reqTagValidIn = 1'b0;
    mem_rdDataIn = '0;
    mem_rdAckIn = 1'b0;
    last_exp.tag = '0;
    last_exp.line = '0;
    #3;
    chk("rst_req", LW'(mem_rdReqOut), '0);
    chk("rst_busy", LW'(busyOut), '0);
    chk("rst_valid", LW'(cache_rspInsLineValidOut), '0);
    chk("rst_tag", LW'(cache_rspTagOut), '0);
    chk("rst_line", cache_rspInsLineOut, '0);
    chk("rst_addr", LW'(mem_rdAddrOut), '0);
    chk("rst_err", LW'(errOut), '0);
    @(negedge Clock);
    @(negedge Clock);
    Rst = 1'b0;
    @(negedge Clock);

    // Known words, zero-wait memory, latency from request edge.
    fixed = 1'b1;
    mem_delay = 0;
    e.tag = 28'h10;
    e.line = 128'h00000044_00000033_00000022_00000011;
    exp_q.push_back(e);
    cache_reqTagIn = 28'h10;
    cache_reqTagValidIn = 1'b1;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (cache_rspInsLineValidOut !== 1'b1 && k < 50);
    chk("latency", LW'(k), LW'(5));
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);
    fixed = 1'b0;
    chk("hold_tag", LW'(cache_rspTagOut), LW'(28'h10));
    chk("hold_valid", LW'(cache_rspInsLineValidOut), '0);

    // Three wait cycles per word; exactly one pulse.
    mem_delay = 3;
    r0 = resp_cnt;
    fill(28'h3A);
    repeat (5) @(negedge Clock);
    chk("one_pulse", LW'(resp_cnt), LW'(r0 + 1));

    // Tag changes mid-fetch while the request stays asserted.
    mem_delay = 1;
    exp_q.push_back(model(28'h10));
    cache_reqTagIn = 28'h10;
    cache_reqTagValidIn = 1'b1;
    repeat (3) @(negedge Clock);
    cache_reqTagIn = 28'h20;
    exp_q.push_back(model(28'h20));
    wait_rsp("chg_first");
    @(negedge Clock);
    chk("gap_idle", LW'(busyOut), '0);
    @(negedge Clock);
    chk("refill_start", LW'({busyOut, mem_rdReqOut}), LW'(2'b11));
    wait_rsp("chg_second");
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);

    // Reset in the middle of a fill.
    mem_delay = 2;
    a0 = ack_cnt;
    exp_q.push_back(model(28'h55));
    cache_reqTagIn = 28'h55;
    cache_reqTagValidIn = 1'b1;
    n = 0;
    while (ack_cnt < a0 + 2 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    @(negedge Clock);
    #2;
    Rst = 1'b1;
    cache_reqTagValidIn = 1'b0;
    void'(exp_q.pop_back());
    mem_idx = 0;
    #1;
    chk("mid_rst_req", LW'(mem_rdReqOut), '0);
    chk("mid_rst_busy", LW'(busyOut), '0);
    chk("mid_rst_tag", LW'(cache_rspTagOut), '0);
    chk("mid_rst_line", cache_rspInsLineOut, '0);
    chk("mid_rst_valid", LW'(cache_rspInsLineValidOut), '0);
    @(negedge Clock);
    @(negedge Clock);
    Rst = 1'b0;
    @(negedge Clock);
    last_exp.tag = '0;
    last_exp.line = '0;
    fill(28'h55);

    // Spurious acks in IDLE change nothing.
    spurious = 1'b1;
    repeat (3) @(negedge Clock);
    chk("spur_busy", LW'(busyOut), '0);
    chk("spur_tag", LW'(cache_rspTagOut), LW'(last_exp.tag));
    chk("spur_line", cache_rspInsLineOut, last_exp.line);
    spurious = 1'b0;
    @(negedge Clock);
    mem_delay = 0;
    fill(28'h0ABCDEF);

`ifdef IFU_MEM_FILL_TIMEOUT_EN
    mem_en = 1'b0;
    cache_reqTagIn = 28'h77;
    cache_reqTagValidIn = 1'b1;
    @(negedge Clock);
    cache_reqTagValidIn = 1'b0;
    n = 1;
    k = 0;
    while (errOut !== 1'b1 && k < 100) begin
      @(negedge Clock);
      k++;
      if (errOut !== 1'b1 && busyOut === 1'b1) n++;
    end
    chk("to_cycles", LW'(n), LW'(TO));
    chk("to_idle", LW'({errOut, busyOut}), LW'(2'b10));
    @(negedge Clock);
    chk("to_pulse", LW'(errOut), '0);
    mem_en = 1'b1;
`else
    mem_en = 1'b0;
    exp_q.push_back(model(28'h77));
    cache_reqTagIn = 28'h77;
    cache_reqTagValidIn = 1'b1;
    @(negedge Clock);
    cache_reqTagValidIn = 1'b0;
    k = 0;
    repeat (100) begin
      @(negedge Clock);
      if (mem_rdReqOut !== 1'b1 || errOut !== 1'b0) k++;
    end
    chk("no_to_hold", LW'(k), '0);
    mem_en = 1'b1;
    wait_rsp("no_to");
    @(negedge Clock);
`endif

    // Random tags with random memory wait states.
    mem_delay = -1;
    repeat (20) fill(TW'($urandom));

    repeat (5) @(negedge Clock);
    chk("drained", LW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
